router_out_arbiter: RTL and testbench

Per-output-channel arbiter and output buffer for the mesh router. It shares one outgoing link (cw, ccw, sn/ns or PE) among up to four internal requesters, which are the router's input channels. It holds one packet per virtual channel (even/odd) and alternates between internal and external virtual-channel use on a free-running polarity bit. One instance sits behind each router output port and drives that port's so/do pins toward the neighbouring router in the mesh row or column.

---
 rtl/router_out_arbiter.sv | 102 ++++++++++
 tb/tb_router_out_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_out_arbiter.sv
// Output-port arbiter and two-slot VC buffer: four input channels share one link,
// with the internal and link sides alternating VC slots on a free-running polarity bit.
// The outgoing packet port is named do_data because "do" is a reserved word.
module router_out_arbiter #(
    parameter int PACKET_WIDTH = 64,
    parameter int NUM_REQ      = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*PACKET_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]              req_gnt,
    output logic                            so,
    input  logic                            ro,
    output logic [PACKET_WIDTH-1:0]         do_data,
    output logic                            polarity_out,
    output logic [1:0]                      buf_full
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic                          p;
    logic [1:0][PTR_W-1:0]         rr;
    logic [1:0]                    full;
    logic [PACKET_WIDTH-1:0]       vc_buf [2];

    logic [NUM_REQ-1:0]            eligible;
    logic                          grant_any;
    logic [PTR_W-1:0]              grant_idx;
    logic [PACKET_WIDTH-1:0]       grant_pkt;

    // A requester may only write the slot the internal side owns this cycle.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i]
                        && (req_data[i*PACKET_WIDTH + PACKET_WIDTH - 1] == p)
                        && !full[p];
        end
    end

    // NOTE: every output of a combinational block gets a default first, otherwise
    // the paths that skip an assignment infer a latch.
    always_comb begin
        logic [PTR_W-1:0] cand;
        grant_any = 1'b0;
        grant_idx = rr[p];
        cand      = rr[p];
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = rr[p] + PTR_W'(k);
            if (!grant_any && eligible[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        grant_pkt = req_data[grant_idx*PACKET_WIDTH +: PACKET_WIDTH];
        req_gnt   = '0;
        if (grant_any && reset) begin
            req_gnt = NUM_REQ'(1) << grant_idx;
        end
    end

    // Write side fills buf[p]; link side drains buf[~p]. The two never collide.
    // NOTE: sequential state is updated with non-blocking assignments so every
    // read in this block sees the pre-edge value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p       <= 1'b0;
            rr      <= '0;
            full    <= '0;
            so      <= 1'b0;
            do_data <= '0;
        end else begin
            p <= ~p;
            if (grant_any) begin
                full[p] <= 1'b1;
                rr[p]   <= grant_idx + PTR_W'(1);
            end
            if (full[~p] && ro) begin
                so       <= 1'b1;
                do_data  <= vc_buf[~p];
                full[~p] <= 1'b0;
            end else begin
                so <= 1'b0;
            end
        end
    end

    // NOTE: the packet storage has no reset; the full flags alone decide whether
    // a slot holds a live packet, so clearing the data would only cost logic.
    always_ff @(posedge clk) begin
        if (grant_any) begin
            vc_buf[p] <= grant_pkt;
        end
    end

    assign polarity_out = p;
    assign buf_full     = full;

endmodule

// File: tb/tb_router_out_arbiter.sv
// Self-checking bench: queue-based reference model of the two VC slots plus
// directed scenarios and a randomized traffic run.
module tb_router_out_arbiter;

    localparam int PW = 64;
    localparam int NR = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR*PW-1:0]  req_data;
    logic [NR-1:0]     req_gnt;
    logic              so;
    logic              ro;
    logic [PW-1:0]     do_data;
    logic              polarity_out;
    logic [1:0]        buf_full;

    logic [PW-1:0]     pkt [NR];

    int errors = 0;
    int checks = 0;

    // Reference model: each VC slot is a queue holding at most one packet.
    logic              m_p;
    int                m_rr [2];
    logic [PW-1:0]     q_even [$];
    logic [PW-1:0]     q_odd  [$];
    logic              m_so;
    logic [PW-1:0]     m_do;
    logic [NR-1:0]     last_gnt;

    assign req_data = {pkt[3], pkt[2], pkt[1], pkt[0]};

    always #5 clk = ~clk;

    router_out_arbiter #(.PACKET_WIDTH(PW), .NUM_REQ(NR)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_gnt      (req_gnt),
        .so           (so),
        .ro           (ro),
        .do_data      (do_data),
        .polarity_out (polarity_out),
        .buf_full     (buf_full)
    );

    function automatic int q_size(input int vc);
        return (vc != 0) ? q_odd.size() : q_even.size();
    endfunction

    function automatic logic [NR-1:0] model_gnt();
        int vc;
        int i;
        if (reset !== 1'b1) return '0;
        vc = int'(m_p);
        if (q_size(vc) != 0) return '0;
        for (int k = 0; k < NR; k++) begin
            i = (m_rr[vc] + k) % NR;
            if (req_valid[i] && (int'(pkt[i][PW-1]) == vc)) return NR'(1) << i;
        end
        return '0;
    endfunction

    task automatic model_reset();
        m_p = 1'b0;
        m_rr[0] = 0;
        m_rr[1] = 0;
        q_even.delete();
        q_odd.delete();
        m_so = 1'b0;
        m_do = '0;
    endtask

    task automatic model_edge(input logic [NR-1:0] g);
        int rd_vc;
        int wr_vc;
        rd_vc = m_p ? 0 : 1;
        wr_vc = int'(m_p);
        if (ro && q_size(rd_vc) != 0) begin
            m_so = 1'b1;
            if (rd_vc != 0) m_do = q_odd.pop_front();
            else            m_do = q_even.pop_front();
        end else begin
            m_so = 1'b0;
        end
        for (int i = 0; i < NR; i++) begin
            if (g[i]) begin
                if (wr_vc != 0) q_odd.push_back(pkt[i]);
                else            q_even.push_back(pkt[i]);
                m_rr[wr_vc] = (i + 1) % NR;
            end
        end
        m_p = ~m_p;
    endtask

    // One clock cycle: called at the falling edge with inputs already driven.
    task automatic cycle();
        logic [NR-1:0] g;
        logic [1:0]    exp_full;
        g = model_gnt();
        exp_full = {q_odd.size() != 0, q_even.size() != 0};
        #1;
        checks++;
        if (req_gnt !== g) begin
            errors++;
            $display("FAIL gnt @%0t: got %b want %b", $time, req_gnt, g);
        end
        checks++;
        if (so !== m_so) begin
            errors++;
            $display("FAIL so @%0t: got %b want %b", $time, so, m_so);
        end
        checks++;
        if (do_data !== m_do) begin
            errors++;
            $display("FAIL do @%0t: got %h want %h", $time, do_data, m_do);
        end
        checks++;
        if (buf_full !== exp_full) begin
            errors++;
            $display("FAIL buf_full @%0t: got %b want %b", $time, buf_full, exp_full);
        end
        checks++;
        if (polarity_out !== m_p) begin
            errors++;
            $display("FAIL polarity @%0t: got %b want %b", $time, polarity_out, m_p);
        end
        last_gnt = g;
        @(posedge clk);
        if (reset === 1'b1) model_edge(g);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        req_valid = '0;
        model_reset();
        cycle();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ro = 1'b1;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            req_valid = NR'($urandom);
            for (int i = 0; i < NR; i++) pkt[i] = {$urandom, $urandom};
            #1;
            checks++;
            if (so !== 1'b0 || do_data !== '0 || polarity_out !== 1'b0 ||
                buf_full !== 2'b00 || req_gnt !== '0) begin
                errors++;
                $display("FAIL reset_state: got so=%b do=%h p=%b full=%b gnt=%b want all zero",
                         so, do_data, polarity_out, buf_full, req_gnt);
            end
            cycle();
        end
        reset = 1'b1;
        req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (polarity_out !== logic'(k % 2)) begin
                errors++;
                $display("FAIL polarity_toggle %0d: got %b want %0d", k, polarity_out, k % 2);
            end
            cycle();
        end
    endtask

    task automatic test_single();
        ro = 1'b1;
        req_valid = '0;
        if (m_p != 1'b0) cycle();
        req_valid = 4'b0001;
        pkt[0] = 64'h0000_0000_0000_00A5;
        #1;
        checks++;
        if (req_gnt !== 4'b0001) begin
            errors++;
            $display("FAIL single_gnt: got %b want 0001", req_gnt);
        end
        cycle();
        req_valid = '0;
        cycle();
        #1;
        checks++;
        if (so !== 1'b1 || do_data !== 64'h0000_0000_0000_00A5 || buf_full !== 2'b00) begin
            errors++;
            $display("FAIL single_out: got so=%b do=%h full=%b want so=1 do=a5 full=00",
                     so, do_data, buf_full);
        end
        cycle();
    endtask

    task automatic test_round_robin();
        int exp_order [5] = '{0, 1, 2, 3, 0};
        logic [NR-1:0] want;
        pulse_reset();
        ro = 1'b1;
        req_valid = 4'b1111;
        for (int i = 0; i < NR; i++) pkt[i] = {1'b0, 31'($urandom), $urandom};
        for (int c = 0; c < 10; c++) begin
            want = (c % 2 == 0) ? (NR'(1) << exp_order[c / 2]) : '0;
            #1;
            checks++;
            if (req_gnt !== want) begin
                errors++;
                $display("FAIL rr_order cycle %0d: got %b want %b", c, req_gnt, want);
            end
            cycle();
            for (int i = 0; i < NR; i++)
                if (last_gnt[i]) pkt[i] = {1'b0, 31'($urandom), $urandom};
        end
        req_valid = '0;
        cycle();
        cycle();
    endtask

    task automatic test_vc_mismatch();
        pulse_reset();
        ro = 1'b1;
        req_valid = 4'b0100;
        pkt[2] = {1'b1, 31'($urandom), $urandom};
        #1;
        checks++;
        if (req_gnt !== 4'b0000) begin
            errors++;
            $display("FAIL vc_mismatch_even: got %b want 0000", req_gnt);
        end
        cycle();
        #1;
        checks++;
        if (req_gnt !== 4'b0100) begin
            errors++;
            $display("FAIL vc_mismatch_odd: got %b want 0100", req_gnt);
        end
        cycle();
        req_valid = '0;
        cycle();
        cycle();
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] first_even;
        int even_seen;
        int odd_seen;
        pulse_reset();
        ro = 1'b0;
        req_valid = 4'b0011;
        pkt[0] = {1'b0, 31'($urandom), $urandom};
        pkt[1] = {1'b1, 31'($urandom), $urandom};
        first_even = pkt[0];
        for (int c = 0; c < 6; c++) begin
            #1;
            if (c >= 1) begin
                checks++;
                if (so !== 1'b0 || buf_full[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_hold cycle %0d: got so=%b full=%b want so=0 full[0]=1",
                             c, so, buf_full);
                end
            end
            if (c >= 2) begin
                checks++;
                if (req_gnt !== '0 || buf_full[1] !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_block cycle %0d: got gnt=%b full=%b want gnt=0000 full=11",
                             c, req_gnt, buf_full);
                end
            end
            cycle();
            if (last_gnt[0]) pkt[0] = {1'b0, 31'($urandom), $urandom};
            if (last_gnt[1]) pkt[1] = {1'b1, 31'($urandom), $urandom};
        end
        ro = 1'b1;
        req_valid = '0;
        even_seen = 0;
        odd_seen = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (so === 1'b1) begin
                if (do_data[PW-1] === 1'b0) begin
                    even_seen++;
                    checks++;
                    if (do_data !== first_even) begin
                        errors++;
                        $display("FAIL bp_data: got %h want %h", do_data, first_even);
                    end
                end else begin
                    odd_seen++;
                end
            end
            cycle();
        end
        checks++;
        if (even_seen != 1 || odd_seen != 1) begin
            errors++;
            $display("FAIL bp_once: got even=%0d odd=%0d want 1 and 1", even_seen, odd_seen);
        end
    endtask

    task automatic test_reset_midflight();
        logic [PW-1:0] dropped;
        pulse_reset();
        ro = 1'b1;
        req_valid = 4'b1000;
        pkt[3] = 64'h0DEA_DBEE_F00D_CAFE;
        dropped = pkt[3];
        cycle();
        req_valid = '0;
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (buf_full !== 2'b00 || so !== 1'b0) begin
            errors++;
            $display("FAIL midflight_clear: got full=%b so=%b want 00 and 0", buf_full, so);
        end
        cycle();
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++;
            if (so === 1'b1 || do_data === dropped) begin
                errors++;
                $display("FAIL midflight_drop cycle %0d: got so=%b do=%h want no dropped packet",
                         c, so, do_data);
            end
            cycle();
        end
    endtask

    task automatic test_random();
        pulse_reset();
        for (int i = 0; i < NR; i++) pkt[i] = {$urandom, $urandom};
        for (int c = 0; c < 400; c++) begin
            ro = ($urandom_range(0, 3) != 0);
            cycle();
            for (int i = 0; i < NR; i++) begin
                if (last_gnt[i] || $urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'($urandom);
                    pkt[i] = {$urandom, $urandom};
                end
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        ro = 1'b0;
        req_valid = '0;
        last_gnt = '0;
        for (int i = 0; i < NR; i++) pkt[i] = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_vc_mismatch();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
